// File: rtl/adder_seq_chunk_pkg.sv
// Shared types and elaboration helpers for the chunked sequential adder.
package adder_seq_chunk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adder_seq_chunk_if.sv
// Operation/result handshake bundle for adder_seq_chunk.
// m_ovf exists only when ADDER_SEQ_CHUNK_OVF_EN is defined.
interface adder_seq_chunk_if #(parameter int WIDTH = 64);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_a;
  logic [WIDTH-1:0] s_b;
  logic             s_ci;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH:0]   m_sum;
`ifdef ADDER_SEQ_CHUNK_OVF_EN
  logic             m_ovf;
`endif

  modport master (
    output s_valid, s_a, s_b, s_ci, m_ready,
`ifdef ADDER_SEQ_CHUNK_OVF_EN
    input  m_ovf,
`endif
    input  s_ready, m_valid, m_sum
  );

  modport slave (
    input  s_valid, s_a, s_b, s_ci, m_ready,
`ifdef ADDER_SEQ_CHUNK_OVF_EN
    output m_ovf,
`endif
    output s_ready, m_valid, m_sum
  );
endinterface

// File: rtl/adder_seq_chunk_bka_r2.sv
// Combinational radix-2 Brent-Kung adder: sum/co = a + b + ci.
module adder_bka_r2 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);
  localparam int LEV = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  always_comb begin
    logic [WIDTH-1:0] gg, pp;
    logic [WIDTH:0]   cv;
    gg = a & b;
    pp = a ^ b;
    gg[0] = gg[0] | (pp[0] & ci);
    // up-sweep builds power-of-two spans, down-sweep fills the remaining prefixes
    for (int l = 0; l < LEV; l++)
      for (int i = 0; i < WIDTH; i++)
        if (((i + 1) % (2 ** (l + 1))) == 0) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (2 ** l)]);
          pp[i] = pp[i] & pp[i - (2 ** l)];
        end
    for (int l = LEV - 2; l >= 0; l--)
      for (int i = 0; i < WIDTH; i++)
        if ((((i + 1) % (2 ** (l + 1))) == (2 ** l)) && (i >= (2 ** (l + 1))))
          gg[i] = gg[i] | (pp[i] & gg[i - (2 ** l)]);
    cv  = {gg, ci};
    sum = (a ^ b) ^ cv[WIDTH-1:0];
    co  = cv[WIDTH];
  end
endmodule

// File: rtl/adder_seq_chunk.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per clock, LSB chunk first.
// Optional signed-overflow output enabled by ADDER_SEQ_CHUNK_OVF_EN.
module adder_seq_chunk
  import adder_seq_chunk_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input logic           clk,
  input logic           rst,
  adder_seq_chunk_if.slave bus
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = cnt_w(NCHUNK);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("adder_seq_chunk: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r, res;
  logic             carry;
  logic [CHUNK-1:0] csum;
  logic             cco;

  adder_bka_r2 #(.WIDTH(CHUNK)) u_add (
    .a   (a_r[CHUNK-1:0]),
    .b   (b_r[CHUNK-1:0]),
    .ci  (carry),
    .sum (csum),
    .co  (cco)
  );

`ifdef ADDER_SEQ_CHUNK_OVF_EN
  logic ovf;
  assign bus.m_ovf = ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      res   <= '0;
      carry <= 1'b0;
`ifdef ADDER_SEQ_CHUNK_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.s_valid) begin
          a_r   <= bus.s_a;
          b_r   <= bus.s_b;
          carry <= bus.s_ci;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          // sum chunks enter at the top so the result is aligned after NCHUNK shifts
          res   <= (res >> CHUNK) | (WIDTH'(csum) << (WIDTH - CHUNK));
          carry <= cco;
          a_r   <= a_r >> CHUNK;
          b_r   <= b_r >> CHUNK;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(NCHUNK - 1)) begin
            state <= DONE;
`ifdef ADDER_SEQ_CHUNK_OVF_EN
            ovf   <= (a_r[CHUNK-1] ^ b_r[CHUNK-1] ^ csum[CHUNK-1]) ^ cco;
`endif
          end
        end
        DONE: if (bus.m_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready = (state == IDLE);
  assign bus.m_valid = (state == DONE);
  assign bus.m_sum   = {carry, res};
endmodule

// File: tb/tb_adder_seq_chunk.sv
// Directed vectors on a CHUNK=16 instance plus random traffic on CHUNK=16/8/64 instances.
module tb_adder_seq_chunk;
  localparam int NOPS = 2000;

  logic clk = 1'b0;
  logic rst_d, rst_r;
  bit   go = 1'b0;
  int   npass = 0;
  int   ntot  = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  adder_seq_chunk_if #(.WIDTH(64)) di();
  adder_seq_chunk #(.WIDTH(64), .CHUNK(16)) dut (.clk(clk), .rst(rst_d), .bus(di));

  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int CH = (gi == 0) ? 16 : (gi == 1) ? 8 : 64;
    adder_seq_chunk_if #(.WIDTH(64)) ri();
    adder_seq_chunk #(.WIDTH(64), .CHUNK(CH)) u_dut (.clk(clk), .rst(rst_r), .bus(ri));
    logic [64:0] expq[$];
    int got = 0;
    bit done = 1'b0;

    initial begin
      ri.s_valid = 1'b0; ri.s_a = '0; ri.s_b = '0; ri.s_ci = 1'b0;
      wait (go);
      for (int n = 0; n < NOPS; n++) begin
        logic [63:0] a, b;
        logic ci;
        int w;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        ci = 1'($urandom_range(0, 1));
        ri.s_valid = 1'b1; ri.s_a = a; ri.s_b = b; ri.s_ci = ci;
        w = 0;
        while (!ri.s_ready && w < 500) begin @(negedge clk); w++; end
        if (!ri.s_ready) begin
          chk($sformatf("rnd_c%0d_ready_timeout", CH), 65'(ri.s_ready), 65'd1);
          break;
        end
        expq.push_back({1'b0, a} + {1'b0, b} + {64'd0, ci});
        @(negedge clk);
        ri.s_valid = 1'b0;
      end
    end

    initial begin
      ri.m_ready = 1'b0;
      wait (go);
      for (int t = 0; t < 90000 && got < NOPS; t++) begin
        @(negedge clk);
        ri.m_ready = 1'($urandom_range(0, 1));
        if (ri.m_valid && ri.m_ready) begin
          if (expq.size() == 0) chk($sformatf("rnd_c%0d_extra", CH), 65'(expq.size()), 65'd1);
          else chk($sformatf("rnd_c%0d_sum", CH), ri.m_sum, expq.pop_front());
          got++;
        end
      end
      chk($sformatf("rnd_c%0d_count", CH), 65'(got), 65'(NOPS));
      done = 1'b1;
    end
  end

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic [64:0] sum;
    logic        ovf;
  } vec_t;

  vec_t tv[10];

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic ci,
                        output logic [64:0] s, output logic o, output int lat);
    @(negedge clk);
    di.s_valid = 1'b1; di.s_a = a; di.s_b = b; di.s_ci = ci;
    @(negedge clk);
    di.s_valid = 1'b0;
    lat = 0;
    while (!di.m_valid && lat < 50) begin @(negedge clk); lat++; end
    s = di.m_sum;
`ifdef ADDER_SEQ_CHUNK_OVF_EN
    o = di.m_ovf;
`else
    o = 1'b0;
`endif
    di.m_ready = 1'b1;
    @(negedge clk);
    di.m_ready = 1'b0;
  endtask

  initial begin
    logic [64:0] s;
    logic o;
    int lat;
    tv[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 65'h1_0000_0000_0000_0000, 1'b0};
    tv[1] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 65'h1_0000_0000_0000_0000, 1'b0};
    tv[2] = '{64'h5, 64'h7, 1'b0, 65'hC, 1'b0};
    tv[3] = '{64'h0, 64'h0, 1'b1, 65'h1, 1'b0};
    tv[4] = '{64'h0, 64'h0, 1'b0, 65'h0, 1'b0};
    tv[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 65'h1_0000_0000_0000_0000, 1'b1};
    tv[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 65'h0_8000_0000_0000_0000, 1'b1};
    tv[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFF, 1'b0};
    tv[8] = '{64'h0000_FFFF_0000_FFFF, 64'h1, 1'b0, 65'h0_0000_FFFF_0001_0000, 1'b0};
    tv[9] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 65'h0_2345_6789_ABCD_F001, 1'b0};

    di.s_valid = 1'b0; di.s_a = '0; di.s_b = '0; di.s_ci = 1'b0; di.m_ready = 1'b0;
    rst_d = 1'b1; rst_r = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 65'(di.s_ready), 65'd1);
    chk("rst_m_valid", 65'(di.m_valid), 65'd0);
    chk("rst_m_sum", di.m_sum, 65'd0);
`ifdef ADDER_SEQ_CHUNK_OVF_EN
    chk("rst_m_ovf", 65'(di.m_ovf), 65'd0);
`endif
    rst_d = 1'b0; rst_r = 1'b0;
    go = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].ci, s, o, lat);
      chk($sformatf("vec%0d_sum", i), s, tv[i].sum);
      chk($sformatf("vec%0d_latency", i), 65'(lat), 65'd4);
`ifdef ADDER_SEQ_CHUNK_OVF_EN
      chk($sformatf("vec%0d_ovf", i), 65'(o), 65'(tv[i].ovf));
`endif
    end
    chk("idle_after_done", 65'(di.s_ready), 65'd1);

    // back-pressure in DONE while new operations are offered
    @(negedge clk);
    di.s_valid = 1'b1; di.s_a = tv[1].a; di.s_b = tv[1].b; di.s_ci = 1'b1;
    @(negedge clk);
    di.s_valid = 1'b0;
    for (int t = 0; t < 50 && !di.m_valid; t++) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      di.s_valid = 1'b1; di.s_a = {$urandom, $urandom}; di.s_b = 64'(k + 1); di.s_ci = 1'b0;
      @(negedge clk);
      chk($sformatf("hold%0d_m_valid", k), 65'(di.m_valid), 65'd1);
      chk($sformatf("hold%0d_m_sum", k), di.m_sum, 65'h1_0000_0000_0000_0000);
      chk($sformatf("hold%0d_s_ready", k), 65'(di.s_ready), 65'd0);
    end
    di.s_valid = 1'b0; di.m_ready = 1'b1;
    @(negedge clk);
    di.m_ready = 1'b0;
    chk("hold_release_m_valid", 65'(di.m_valid), 65'd0);
    chk("hold_release_s_ready", 65'(di.s_ready), 65'd1);

    // abort in the second RUN cycle
    di.s_valid = 1'b1; di.s_a = 64'hFFFF_FFFF_FFFF_FFFF; di.s_b = 64'h1; di.s_ci = 1'b0;
    @(negedge clk);
    di.s_valid = 1'b0;
    @(negedge clk);
    chk("abort_pre_s_ready", 65'(di.s_ready), 65'd0);
    rst_d = 1'b1;
    #1;
    chk("abort_m_valid", 65'(di.m_valid), 65'd0);
    chk("abort_m_sum", di.m_sum, 65'd0);
    chk("abort_s_ready", 65'(di.s_ready), 65'd1);
    @(negedge clk);
    rst_d = 1'b0;
    run_op(64'd5, 64'd7, 1'b0, s, o, lat);
    chk("post_abort_sum", s, 65'd12);
    chk("post_abort_latency", 65'(lat), 65'd4);

    for (int t = 0; t < 95000 && !(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done); t++)
      @(negedge clk);
    chk("rnd_all_done", 65'({g_rnd[0].done, g_rnd[1].done, g_rnd[2].done}), 65'd7);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
